// File: rtl/etcpu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// etcpu_dmem_ctrl
//
// Data-memory controller sitting on the core's main-memory port. It turns the
// core's single-cycle load/store request into a registered req/ack
// transaction toward a variable-latency memory or bus. While the transaction
// is in flight the core is stalled. Misaligned word accesses and bus timeouts
// are reported through sticky error bits.
//
// Handshake (bus side): bus_req_o rises on the edge after the core request is
// accepted and stays high, with bus_we_o/bus_addr_o/bus_wdat_o frozen, until
// the first edge at which bus_ack_i=1 (or the timeout aborts). bus_ack_i is
// only looked at while bus_req_o=1; bus_rdat_i is sampled on that same edge.
// Core side: the core holds cpu_cs_i and its operands while cpu_stall_o=1 and
// retires the request in the first cycle where cpu_stall_o=0.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cpu_cs_i          core access request
//   cpu_wen_i         1 = store, 0 = load
//   cpu_addr_i        byte address (word accesses only)
//   cpu_wdat_i        store data
//   cpu_rdat_o        load data, valid in the DONE cycle
//   cpu_stall_o       core must hold pipeline and request while high
//   bus_req_o         bus request (registered)
//   bus_we_o          bus write enable (registered)
//   bus_addr_o        bus byte address (registered)
//   bus_wdat_o        bus write data (registered)
//   bus_ack_i         bus completion, meaningful only while bus_req_o=1
//   bus_rdat_i        bus read data
//   err_clr_i         clears both sticky error bits
//   err_misalign_o    sticky: access with cpu_addr_i[1:0] != 0
//   err_timeout_o     sticky: bus did not answer within TIMEOUT cycles
//   state_o           current FSM state (debug)
// -----------------------------------------------------------------------------
module etcpu_dmem_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cs_i,
    input  logic              cpu_wen_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdat_i,
    output logic [31:0]       cpu_rdat_o,
    output logic              cpu_stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdat_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdat_i,
    input  logic              err_clr_i,
    output logic              err_misalign_o,
    output logic              err_timeout_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
    // Value the wait counter holds during the last REQ cycle that is allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdat_q, bus_wdat_d;
    logic [31:0]         rdat_q, rdat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_mis_q, err_mis_d;
    logic                err_to_q, err_to_d;
    logic                mis_set, to_set, stall;
    logic                aligned;

    assign aligned = (cpu_addr_i[1:0] == 2'b00);

    // Upper address bits are outside the bus window and intentionally dropped.
    generate
        if (ADDR_W < 32) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^cpu_addr_i[31:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_wdat_q <= '0;
            rdat_q     <= '0;
            cnt_q      <= '0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_wdat_q <= bus_wdat_d;
            rdat_q     <= rdat_d;
            cnt_q      <= cnt_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_wdat_d = bus_wdat_q;
        rdat_d     = rdat_q;
        cnt_d      = cnt_q;
        mis_set    = 1'b0;
        to_set     = 1'b0;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_cs_i) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        state_d    = REQ;
                        bus_req_d  = 1'b1;
                        bus_we_d   = cpu_wen_i;
                        bus_addr_d = cpu_addr_i[ADDR_W-1:0];
                        bus_wdat_d = cpu_wdat_i;
                        cnt_d      = '0;
                    end else begin
                        // Misaligned: answered immediately with zero data,
                        // a store is simply dropped.
                        rdat_d  = '0;
                        mis_set = 1'b1;
                    end
                end
            end

            REQ: begin
                stall = 1'b1;
                // An ack on the expiry edge is checked first so it wins.
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (!bus_we_q) begin
                        rdat_d = bus_rdat_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    to_set    = 1'b1;
                    if (!bus_we_q) begin
                        rdat_d = ERR_DATA;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                // cpu_cs_i here still belongs to the request just served.
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        // Set beats clear so an event coinciding with err_clr is not lost.
        err_mis_d = mis_set | (err_mis_q & ~err_clr_i);
        err_to_d  = to_set  | (err_to_q  & ~err_clr_i);
    end

    assign cpu_stall_o    = stall;
    assign cpu_rdat_o     = rdat_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdat_o     = bus_wdat_q;
    assign err_misalign_o = err_mis_q;
    assign err_timeout_o  = err_to_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_etcpu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_etcpu_dmem_ctrl
//
// Directed bench for etcpu_dmem_ctrl with TIMEOUT=4. Inputs are driven just
// after the falling edge and outputs are sampled 1 ns later, so each "cycle"
// below is the interval between two rising edges as seen from its middle.
// -----------------------------------------------------------------------------
module tb_etcpu_dmem_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_cs_i = 1'b0;
  logic        cpu_wen_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdat_i = '0;
  logic [31:0] cpu_rdat_o;
  logic        cpu_stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [15:0] bus_addr_o;
  logic [31:0] bus_wdat_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdat_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_misalign_o;
  logic        err_timeout_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of accepted bus transactions: {we, addr}.
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  etcpu_dmem_ctrl #(
    .ADDR_W  (16),
    .TIMEOUT (4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_cs_i      (cpu_cs_i),
    .cpu_wen_i     (cpu_wen_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wdat_i    (cpu_wdat_i),
    .cpu_rdat_o    (cpu_rdat_o),
    .cpu_stall_o   (cpu_stall_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdat_o    (bus_wdat_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdat_i    (bus_rdat_i),
    .err_clr_i     (err_clr_i),
    .err_misalign_o(err_misalign_o),
    .err_timeout_o (err_timeout_o),
    .state_o       (state_o)
  );

  // Bus monitor: records each handshake after this cycle's drives settle.
  always @(negedge clk) begin
    #2;
    if (bus_req_o === 1'b1 && bus_ack_i === 1'b1)
      got_q.push_back({bus_we_o, bus_addr_o});
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    settle();
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d want %0d", state_o, S_IDLE); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_bus_req: got %0b want 0", bus_req_o); end
    n_checks++; if (bus_we_o !== 1'b0) begin n_errors++; $display("FAIL rst_bus_we: got %0b want 0", bus_we_o); end
    n_checks++; if (bus_addr_o !== 16'h0000) begin n_errors++; $display("FAIL rst_bus_addr: got %h want 0000", bus_addr_o); end
    n_checks++; if (bus_wdat_o !== 32'h0) begin n_errors++; $display("FAIL rst_bus_wdat: got %h want 0", bus_wdat_o); end
    n_checks++; if (cpu_rdat_o !== 32'h0) begin n_errors++; $display("FAIL rst_rdat: got %h want 0", cpu_rdat_o); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %0b want 0", cpu_stall_o); end
    n_checks++; if ({err_misalign_o, err_timeout_o} !== 2'b00) begin n_errors++; $display("FAIL rst_errs: got %b want 00", {err_misalign_o, err_timeout_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_0wait();
    // cycle 1: IDLE, request presented
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h0000_0100; settle();
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_errors++; $display("FAIL rd0_stall_c1: got %0b want 1", cpu_stall_o); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL rd0_req_c1: got %0b want 0", bus_req_o); end
    // cycle 2: REQ, ack immediately
    step(); bus_ack_i = 1'b1; bus_rdat_i = 32'h1234_5678; settle();
    n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL rd0_req_c2: got %0b want 1", bus_req_o); end
    n_checks++; if (bus_addr_o !== 16'h0100) begin n_errors++; $display("FAIL rd0_addr: got %h want 0100", bus_addr_o); end
    n_checks++; if (bus_we_o !== 1'b0) begin n_errors++; $display("FAIL rd0_we: got %0b want 0", bus_we_o); end
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_errors++; $display("FAIL rd0_stall_c2: got %0b want 1", cpu_stall_o); end
    // cycle 3: DONE, data delivered
    step(); bus_ack_i = 1'b0; bus_rdat_i = 32'h0; settle();
    n_checks++; if (state_o !== S_DONE) begin n_errors++; $display("FAIL rd0_state_c3: got %0d want %0d", state_o, S_DONE); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rd0_stall_c3: got %0b want 0", cpu_stall_o); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL rd0_req_c3: got %0b want 0", bus_req_o); end
    n_checks++; if (cpu_rdat_o !== 32'h1234_5678) begin n_errors++; $display("FAIL rd0_rdat: got %h want 12345678", cpu_rdat_o); end
    step(); cpu_cs_i = 1'b0; settle();
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL rd0_state_c4: got %0d want %0d", state_o, S_IDLE); end
  endtask

  task automatic test_write_3wait();
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b1; cpu_addr_i = 32'h0000_2004; cpu_wdat_i = 32'hA5A5_A5A5; settle();
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_errors++; $display("FAIL wr3_stall_c1: got %0b want 1", cpu_stall_o); end
    // four REQ cycles, ack on the fourth
    for (int i = 0; i < 4; i++) begin
      step(); bus_ack_i = (i == 3); settle();
      n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL wr3_req_c%0d: got %0b want 1", i + 2, bus_req_o); end
      n_checks++; if (bus_we_o !== 1'b1) begin n_errors++; $display("FAIL wr3_we_c%0d: got %0b want 1", i + 2, bus_we_o); end
      n_checks++; if (bus_addr_o !== 16'h2004) begin n_errors++; $display("FAIL wr3_addr_c%0d: got %h want 2004", i + 2, bus_addr_o); end
      n_checks++; if (bus_wdat_o !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL wr3_wdat_c%0d: got %h want a5a5a5a5", i + 2, bus_wdat_o); end
      n_checks++; if (cpu_stall_o !== 1'b1) begin n_errors++; $display("FAIL wr3_stall_c%0d: got %0b want 1", i + 2, cpu_stall_o); end
    end
    step(); bus_ack_i = 1'b0; settle();
    n_checks++; if (state_o !== S_DONE) begin n_errors++; $display("FAIL wr3_state_done: got %0d want %0d", state_o, S_DONE); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL wr3_stall_done: got %0b want 0", cpu_stall_o); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL wr3_req_done: got %0b want 0", bus_req_o); end
    n_checks++; if (err_timeout_o !== 1'b0) begin n_errors++; $display("FAIL wr3_err_to: got %0b want 0", err_timeout_o); end
    // a store leaves the previous load data in place
    n_checks++; if (cpu_rdat_o !== 32'h1234_5678) begin n_errors++; $display("FAIL wr3_rdat_hold: got %h want 12345678", cpu_rdat_o); end
    step(); cpu_cs_i = 1'b0; cpu_wen_i = 1'b0; settle();
  endtask

  task automatic test_misaligned();
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b1; cpu_addr_i = 32'h0000_0103; cpu_wdat_i = 32'h5555_AAAA; settle();
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL mis_stall: got %0b want 0", cpu_stall_o); end
    step(); cpu_cs_i = 1'b0; cpu_wen_i = 1'b0; settle();
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL mis_req: got %0b want 0", bus_req_o); end
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL mis_state: got %0d want %0d", state_o, S_IDLE); end
    n_checks++; if (err_misalign_o !== 1'b1) begin n_errors++; $display("FAIL mis_err_set: got %0b want 1", err_misalign_o); end
    n_checks++; if (cpu_rdat_o !== 32'h0) begin n_errors++; $display("FAIL mis_rdat: got %h want 0", cpu_rdat_o); end
    n_checks++; if (bus_wdat_o !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL mis_wdat_hold: got %h want a5a5a5a5", bus_wdat_o); end
    step(); err_clr_i = 1'b1; settle();
    n_checks++; if (err_misalign_o !== 1'b1) begin n_errors++; $display("FAIL mis_err_preclr: got %0b want 1", err_misalign_o); end
    step(); err_clr_i = 1'b0; settle();
    n_checks++; if (err_misalign_o !== 1'b0) begin n_errors++; $display("FAIL mis_err_clr: got %0b want 0", err_misalign_o); end
    // set and clear in the same cycle: set wins
    step(); cpu_cs_i = 1'b1; cpu_addr_i = 32'h0000_0101; err_clr_i = 1'b1; settle();
    step(); cpu_cs_i = 1'b0; err_clr_i = 1'b0; settle();
    n_checks++; if (err_misalign_o !== 1'b1) begin n_errors++; $display("FAIL mis_set_wins: got %0b want 1", err_misalign_o); end
    step(); err_clr_i = 1'b1; settle();
    step(); err_clr_i = 1'b0; settle();
    n_checks++; if (err_misalign_o !== 1'b0) begin n_errors++; $display("FAIL mis_err_clr2: got %0b want 0", err_misalign_o); end
  endtask

  task automatic test_timeout();
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h0000_0040; settle();
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL to_req_c%0d: got %0b want 1", i + 2, bus_req_o); end
    end
    step(); settle();
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL to_req_drop: got %0b want 0", bus_req_o); end
    n_checks++; if (state_o !== S_DONE) begin n_errors++; $display("FAIL to_state: got %0d want %0d", state_o, S_DONE); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL to_stall: got %0b want 0", cpu_stall_o); end
    n_checks++; if (cpu_rdat_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL to_rdat: got %h want deadbeef", cpu_rdat_o); end
    n_checks++; if (err_timeout_o !== 1'b1) begin n_errors++; $display("FAIL to_err: got %0b want 1", err_timeout_o); end
    // late ack with no request outstanding must be ignored
    step(); cpu_cs_i = 1'b0; bus_ack_i = 1'b1; bus_rdat_i = 32'h7777_7777; err_clr_i = 1'b1; settle();
    step(); bus_ack_i = 1'b0; err_clr_i = 1'b0; settle();
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL to_late_ack_state: got %0d want %0d", state_o, S_IDLE); end
    n_checks++; if (cpu_rdat_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL to_late_ack_rdat: got %h want deadbeef", cpu_rdat_o); end
    n_checks++; if (err_timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_err_clr: got %0b want 0", err_timeout_o); end
    // ack on the last allowed REQ cycle wins over expiry
    step(); cpu_cs_i = 1'b1; cpu_addr_i = 32'h0000_0044; settle();
    for (int i = 0; i < 4; i++) begin
      step(); bus_ack_i = (i == 3); bus_rdat_i = 32'h1357_2468; settle();
      n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL to_edge_req_c%0d: got %0b want 1", i + 2, bus_req_o); end
    end
    step(); bus_ack_i = 1'b0; settle();
    n_checks++; if (cpu_rdat_o !== 32'h1357_2468) begin n_errors++; $display("FAIL to_edge_rdat: got %h want 13572468", cpu_rdat_o); end
    n_checks++; if (err_timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_edge_err: got %0b want 0", err_timeout_o); end
    step(); cpu_cs_i = 1'b0; settle();
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({1'b0, 16'h0010});
    exp_q.push_back({1'b1, 16'h0014});
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h0000_0010; settle();
    step(); bus_ack_i = 1'b1; bus_rdat_i = 32'hCAFE_0010; settle();
    n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL b2b_req1: got %0b want 1", bus_req_o); end
    step(); bus_ack_i = 1'b0; settle();
    n_checks++; if (cpu_rdat_o !== 32'hCAFE_0010) begin n_errors++; $display("FAIL b2b_rdat1: got %h want cafe0010", cpu_rdat_o); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL b2b_stall_done1: got %0b want 0", cpu_stall_o); end
    // core moves on to the store; cs never dropped
    step(); cpu_wen_i = 1'b1; cpu_addr_i = 32'h0000_0014; cpu_wdat_i = 32'h1122_3344; settle();
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL b2b_no_reissue: got %0b want 0", bus_req_o); end
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL b2b_idle: got %0d want %0d", state_o, S_IDLE); end
    step(); bus_ack_i = 1'b1; settle();
    n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL b2b_req2: got %0b want 1", bus_req_o); end
    n_checks++; if (bus_wdat_o !== 32'h1122_3344) begin n_errors++; $display("FAIL b2b_wdat2: got %h want 11223344", bus_wdat_o); end
    step(); bus_ack_i = 1'b0; cpu_cs_i = 1'b0; settle();
    n_checks++; if (cpu_rdat_o !== 32'hCAFE_0010) begin n_errors++; $display("FAIL b2b_rdat_hold: got %h want cafe0010", cpu_rdat_o); end
    step(); settle();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_txn_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_txn%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_req();
    // leave a sticky error behind so reset clearing it is observable
    step(); cpu_cs_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h0000_0082; settle();
    step(); cpu_addr_i = 32'h0000_0080; settle();
    n_checks++; if (err_misalign_o !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_err: got %0b want 1", err_misalign_o); end
    step(); rst_n = 1'b0; settle();
    n_checks++; if (bus_req_o !== 1'b1) begin n_errors++; $display("FAIL rmid_req_before: got %0b want 1", bus_req_o); end
    step(); rst_n = 1'b1; cpu_cs_i = 1'b0; settle();
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL rmid_req_after: got %0b want 0", bus_req_o); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rmid_stall: got %0b want 0", cpu_stall_o); end
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL rmid_state: got %0d want %0d", state_o, S_IDLE); end
    n_checks++; if ({err_misalign_o, err_timeout_o} !== 2'b00) begin n_errors++; $display("FAIL rmid_errs: got %b want 00", {err_misalign_o, err_timeout_o}); end
    step(); bus_ack_i = 1'b1; bus_rdat_i = 32'hFFFF_FFFF; settle();
    step(); bus_ack_i = 1'b0; settle();
    n_checks++; if (state_o !== S_IDLE) begin n_errors++; $display("FAIL rmid_late_state: got %0d want %0d", state_o, S_IDLE); end
    n_checks++; if (cpu_rdat_o !== 32'h0) begin n_errors++; $display("FAIL rmid_late_rdat: got %h want 0", cpu_rdat_o); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_errors++; $display("FAIL rmid_late_req: got %0b want 0", bus_req_o); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_read_0wait();
    test_write_3wait();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/etcpu_dmem_ctrl.md
Name: etcpu_dmem_ctrl

Overview:
- Data-memory controller on the core's main-memory port (cs/wen/addr/dat_in/dat_out), downstream of the memory-access stage.
- Converts the core's single-cycle access into a req/ack transaction toward a variable-latency data memory or bus.
- Stalls the core until the transaction completes.
- Flags misaligned accesses and bus timeouts in sticky error bits.

Parameters:
ADDR_W, 16, bus address width; bus_addr = cpu_addr[ADDR_W-1:0].
TIMEOUT, 64, max cycles bus_req may stay high without bus_ack before abort; range 1..65535.
ERR_DATA, 32'hDEAD_BEEF, value returned on cpu_rdat for an aborted (timed-out) read.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_cs  in  1  core access request; held stable by core while cpu_stall=1
cpu_wen  in  1  1=store, 0=load
cpu_addr  in  32  byte address, word access only
cpu_wdat  in  32  store data
cpu_rdat  out  32  load data, valid in DONE cycle
cpu_stall  out  1  core must hold pipeline and request while high
bus_req  out  1  bus request, registered
bus_we  out  1  bus write enable, registered
bus_addr  out  ADDR_W  bus word-aligned byte address, registered
bus_wdat  out  32  bus write data, registered
bus_ack  in  1  completion; valid only while bus_req=1
bus_rdat  in  32  read data, sampled when bus_req&bus_ack
err_clr  in  1  clears sticky error bits
err_misalign  out  1  sticky: access with cpu_addr[1:0]!=0
err_timeout  out  1  sticky: TIMEOUT expired

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdat=0, cpu_rdat=0, counter=0, err_misalign=0, err_timeout=0.
  - Reset mid-transaction: abandon it; bus_req low after the reset edge; no error set.
- States: IDLE, REQ, DONE.
- IDLE, cpu_cs=1, aligned:
  - cpu_stall=1 combinationally.
  - Next edge: state=REQ, bus_req=1; bus_we/addr/wdat captured from cpu_*; counter=0.
- IDLE, cpu_cs=1, misaligned:
  - cpu_stall=0; no bus transaction.
  - cpu_rdat=0 next cycle; err_misalign set; state stays IDLE. Store is dropped.
- IDLE, cpu_cs=0: cpu_stall=0; outputs hold.
- REQ:
  - cpu_stall=1; bus_req, bus_we, bus_addr, bus_wdat held stable.
  - bus_ack=1 at edge: bus_req=0, state=DONE. For a read, cpu_rdat<=bus_rdat; for a write, cpu_rdat holds its previous value.
  - bus_ack=0: counter++. If counter==TIMEOUT-1 at the edge, abort: bus_req=0, state=DONE, cpu_rdat<=ERR_DATA (reads only), err_timeout set.
  - bus_ack arriving the same edge as expiry wins: normal completion, no error.
- DONE:
  - cpu_stall=0; the core consumes cpu_rdat and retires the held request.
  - Next edge: state=IDLE, regardless of cpu_cs; cpu_cs in DONE is the already-served request.
- Latency:
  - Ack on first REQ cycle gives 2 stall cycles (IDLE, REQ), data in the 3rd cycle (DONE).
  - Each extra wait cycle adds one stall cycle.
  - Back-to-back requests cost a minimum of 3 cycles each.
- bus_ack while bus_req=0 is ignored.
- Errors:
  - err_clr=1 clears both bits next edge.
  - A set event in the same cycle as err_clr wins, so the bit stays 1.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

Test Plan:
- Read, 0 wait: cpu_cs=1, wen=0, addr=0x100, bus_ack=1 in first REQ cycle, bus_rdat=0x12345678 -> bus_req high exactly 1 cycle with bus_addr=0x0100; stall high 2 cycles; cpu_rdat=0x12345678 in 3rd cycle with stall=0.
- Write, 3 waits: wen=1, addr=0x2004, wdat=0xA5A5A5A5, ack after 3 REQ cycles -> bus_we=1, bus_wdat=0xA5A5A5A5 stable over 4 REQ cycles; stall high 5 cycles; no error.
- Misaligned: addr=0x103 with cs -> bus_req never rises, stall=0, err_misalign=1 next cycle; err_clr pulse -> err_misalign=0.
- Timeout (TIMEOUT=4), bus_ack never asserted -> bus_req high 4 cycles then low, cpu_rdat=0xDEADBEEF in DONE, err_timeout=1; ack on the 4th cycle instead -> normal data, err_timeout=0.
- Back-to-back: load 0x10 then store 0x14 with cs held continuously, ack immediate -> two distinct bus transactions, 3 cycles apart, correct order, DONE cycle not re-issued.
- Reset mid-REQ: rst_n=0 for 1 cycle while bus_req=1 -> bus_req=0, stall=0, state IDLE, errors 0; a later late bus_ack is ignored.
